// File: rtl/rst_seq.sv
// rst_seq: parametrised reset sequencer driving NUM_DOMAINS independently timed resets.
// Ports: wb_clk_i/wb_rst_i (clock, sync active-high reset), hold_i (stall in HOLD),
//        sw_rst_req_i (restart request), rst_o/done_o/state_o/sw_rst_cnt_o (all registered).
module rst_seq #(
  parameter int NUM_DOMAINS = 4,
  parameter int CNT_WIDTH   = 8,
  parameter int MIN_ASSERT  = 16,
  parameter logic [NUM_DOMAINS*CNT_WIDTH-1:0] RELEASE_DELAYS = {8'd40, 8'd30, 8'd20, 8'd10}
) (
  input  logic                   wb_clk_i,
  input  logic                   wb_rst_i,
  input  logic                   hold_i,
  input  logic                   sw_rst_req_i,
  output logic [NUM_DOMAINS-1:0] rst_o,
  output logic                   done_o,
  output logic [2:0]             state_o,
  output logic [7:0]             sw_rst_cnt_o
);

  typedef enum logic [2:0] {
    ST_ASSERT  = 3'd0,
    ST_HOLD    = 3'd1,
    ST_RELEASE = 3'd2,
    ST_RUN     = 3'd3
  } state_t;

  localparam logic [CNT_WIDTH-1:0] CNT_MAX  = {CNT_WIDTH{1'b1}};
  localparam logic [CNT_WIDTH-1:0] MIN_LAST = CNT_WIDTH'(MIN_ASSERT - 1);

  state_t                 state_q, state_d;
  logic [CNT_WIDTH-1:0]   cnt_q, cnt_d, cnt_inc;
  logic [NUM_DOMAINS-1:0] rst_q, rst_d;
  logic                   done_q, done_d;
  logic [7:0]             swcnt_q, swcnt_d;
  logic                   sw_accept;

  always_ff @(posedge wb_clk_i) begin
    if (wb_rst_i) begin
      state_q <= ST_ASSERT;
      cnt_q   <= '0;
      rst_q   <= '1;
      done_q  <= 1'b0;
      swcnt_q <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rst_q   <= rst_d;
      done_q  <= done_d;
      swcnt_q <= swcnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rst_d   = rst_q;
    done_d  = done_q;
    swcnt_d = swcnt_q;
    // Saturating increment: the counter parks at its maximum so a delay of
    // CNT_MAX still releases once the counter reads that value.
    cnt_inc = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
    // Requests arriving during ASSERT only stretch the assertion; they are
    // not a new restart, so a held level counts exactly once.
    sw_accept = sw_rst_req_i && (state_q != ST_ASSERT);

    case (state_q)
      ST_ASSERT: begin
        rst_d  = '1;
        done_d = 1'b0;
        if (sw_rst_req_i) begin
          cnt_d = '0;
        end else if (cnt_q == MIN_LAST) begin
          state_d = ST_HOLD;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_inc;
        end
      end
      ST_HOLD: begin
        rst_d = '1;
        if (!hold_i) begin
          state_d = ST_RELEASE;
          cnt_d   = '0;
        end
      end
      ST_RELEASE: begin
        // Once a domain is released it stays released (AND with own state).
        for (int i = 0; i < NUM_DOMAINS; i++) begin
          rst_d[i] = rst_q[i] & (cnt_q < RELEASE_DELAYS[i*CNT_WIDTH +: CNT_WIDTH]);
        end
        cnt_d = cnt_inc;
        if (rst_d == '0) begin
          state_d = ST_RUN;
          done_d  = 1'b1;
        end
      end
      ST_RUN: begin
        rst_d  = '0;
        done_d = 1'b1;
      end
      default: begin
        state_d = ST_ASSERT;
        cnt_d   = '0;
        rst_d   = '1;
        done_d  = 1'b0;
      end
    endcase

    // Restart overrides whatever the state decided, including hold_i in HOLD.
    if (sw_accept) begin
      state_d = ST_ASSERT;
      cnt_d   = '0;
      rst_d   = '1;
      done_d  = 1'b0;
      swcnt_d = (swcnt_q == 8'hFF) ? swcnt_q : swcnt_q + 8'd1;
    end
  end

  assign rst_o        = rst_q;
  assign done_o       = done_q;
  assign state_o      = state_q;
  assign sw_rst_cnt_o = swcnt_q;

endmodule
